cc_coef_scheduler: RTL and testbench

Frame-synchronous coefficient loader for `color_corrector`. A host writes the 12 colour-matrix coefficients a11..a34 into a shadow bank at any time, then issues a commit. The block waits for the next start-of-frame on the corrector's input stream and briefly holds that stream. It then sequences the coefficients onto `cc_ctrl_if`, one per cycle, so no frame is processed with a mixed coefficient set.

---
 rtl/cc_ctrl_if.sv | 8 +
 rtl/cc_coef_scheduler.sv | 129 ++++++++++++
 tb/tb_cc_coef_scheduler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cc_ctrl_if.sv
// cc_ctrl_if: coefficient write port into color_corrector (coef_sel, coef, coef_lock)
interface cc_ctrl_if;
    logic [3:0]  coef_sel;
    logic [31:0] coef;
    logic        coef_lock;
    modport master (output coef_sel, coef, coef_lock);
    modport slave  (input coef_sel, coef, coef_lock);
endinterface

// File: rtl/cc_coef_scheduler.sv
// cc_coef_scheduler: frame-synchronous coefficient loader for color_corrector; SOF sync enabled by CC_SCHED_SOF_SYNC_EN
module cc_coef_scheduler #(
    parameter int PX_WIDTH     = 10,
    parameter int FRACT_WIDTH  = 10,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            wr_en_i,
    input  logic [3:0]                      wr_sel_i,
    input  logic [PX_WIDTH+FRACT_WIDTH:0]   wr_data_i,
    input  logic                            commit_i,
    input  logic                            vid_tvalid_i,
    input  logic                            vid_tuser_i,
    output logic                            hold_o,
    output logic                            busy_o,
    output logic                            done_o,
    cc_ctrl_if.master                       cc_ctrl_o
);
    localparam int CW = PX_WIDTH + FRACT_WIDTH + 1;
    typedef enum logic [1:0] {IDLE, WAIT_SOF, DRAIN, LOAD} state_t;
    state_t        state;
    logic [CW-1:0] shadow [12];
    logic [CW-1:0] staging [12];
    logic [CW-1:0] shadow_nxt [12];
    logic [CW-1:0] stage_nxt [12];
    logic [3:0]    idx, cnt;
    logic          pending, hold_r, last, pend_now, copy, start, sof;

    function automatic logic [CW-1:0] init_coef(input int i);
        case (i)
            0:       init_coef = CW'(21'h000400);
            1:       init_coef = CW'(21'h000000);
            2:       init_coef = CW'(21'h00059C);
            3:       init_coef = CW'(21'h12CD80);
            4:       init_coef = CW'(21'h000400);
            5:       init_coef = CW'(21'h100160);
            6:       init_coef = CW'(21'h1002DB);
            7:       init_coef = CW'(21'h021E00);
            8:       init_coef = CW'(21'h000400);
            9:       init_coef = CW'(21'h000717);
            10:      init_coef = CW'(21'h000000);
            11:      init_coef = CW'(21'h138B33);
            default: init_coef = '0;
        endcase
    endfunction

    // next-state of both banks: host writes into shadow, commits copy shadow (incl. same-cycle write) into staging
    always_comb begin
        last     = state == LOAD && idx == 4'd11;
        pend_now = pending || (commit_i && (state == DRAIN || state == LOAD));
        copy     = (commit_i && (state == IDLE || state == WAIT_SOF)) || (last && pend_now);
        for (int i = 0; i < 12; i++) begin
            shadow_nxt[i] = (wr_en_i && wr_sel_i == 4'(i)) ? wr_data_i : shadow[i];
            stage_nxt[i]  = copy ? shadow_nxt[i] : staging[i];
        end
    end

`ifdef CC_SCHED_SOF_SYNC_EN
    assign sof    = vid_tvalid_i & vid_tuser_i;
    assign start  = (state == WAIT_SOF && sof && DRAIN_CYCLES == 0) || (state == DRAIN && cnt == 4'd0);
    assign hold_o = (state == WAIT_SOF) ? sof : hold_r;
`else
    logic unused;
    assign unused = &{1'b0, vid_tvalid_i, vid_tuser_i, hold_r};
    assign sof    = 1'b0;
    assign start  = (state == IDLE && commit_i) || (last && pend_now);
    assign hold_o = 1'b0;
`endif
    assign busy_o = state != IDLE;

    // shadow and staging banks, both starting from the corrector's init set
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 12; i++) begin
                shadow[i]  <= init_coef(i);
                staging[i] <= init_coef(i);
            end
        end else begin
            shadow  <= shadow_nxt;
            staging <= stage_nxt;
        end
    end

    // control FSM: SOF wait, drain count, 12-beat load with registered write port, done pulse and hold
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state               <= IDLE;
            idx                 <= '0;
            cnt                 <= '0;
            pending             <= 1'b0;
            hold_r              <= 1'b0;
            done_o              <= 1'b0;
            cc_ctrl_o.coef_lock <= 1'b0;
            cc_ctrl_o.coef_sel  <= '0;
            cc_ctrl_o.coef      <= '0;
        end else begin
            done_o  <= 1'b0;
            pending <= last ? 1'b0 : pend_now;
            case (state)
                IDLE: if (commit_i) state <= WAIT_SOF;
                WAIT_SOF: if (sof && DRAIN_CYCLES != 0) begin
                    state  <= DRAIN;
                    cnt    <= 4'(DRAIN_CYCLES - 1);
                    hold_r <= 1'b1;
                end
                DRAIN: cnt <= cnt - 4'd1;
                LOAD: if (last) begin
                    state               <= pend_now ? WAIT_SOF : IDLE;
                    done_o              <= 1'b1;
                    hold_r              <= 1'b0;
                    cc_ctrl_o.coef_lock <= 1'b0;
                end else begin
                    idx                <= idx + 4'd1;
                    cc_ctrl_o.coef_sel <= idx + 4'd1;
                    cc_ctrl_o.coef     <= 32'(staging[idx + 4'd1]);
                end
            endcase
            if (start) begin
                state               <= LOAD;
                idx                 <= '0;
                hold_r              <= 1'b1;
                cc_ctrl_o.coef_lock <= 1'b1;
                cc_ctrl_o.coef_sel  <= '0;
                cc_ctrl_o.coef      <= 32'(stage_nxt[0]);
            end
        end
    end
endmodule

// File: tb/tb_cc_coef_scheduler.sv
// tb_cc_coef_scheduler: directed checks of commit, SOF sync, pending reload and reset for cc_coef_scheduler
module tb_cc_coef_scheduler;
    localparam int CW = 21;
`ifdef CC_SCHED_SOF_SYNC_EN
    localparam int E_LEN = 13;
`else
    localparam int E_LEN = 7;
`endif
    typedef struct {int c; logic [3:0] s; logic [CW-1:0] d;} wr_t;
    logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, commit = 1'b0, tvalid = 1'b0, tuser = 1'b0;
    logic [3:0] wr_sel = '0;
    logic [CW-1:0] wr_data = '0;
    logic hold_a, busy_a, done_a;
    int errors = 0, checks = 0, cyc = 0;
    wr_t wq[$];
    logic [CW-1:0] e1 [12];
    logic [CW-1:0] e2 [12];
    logic [CW-1:0] init_tab [12] = '{21'h000400, 21'h000000, 21'h00059C, 21'h12CD80,
                                     21'h000400, 21'h100160, 21'h1002DB, 21'h021E00,
                                     21'h000400, 21'h000717, 21'h000000, 21'h138B33};

    cc_ctrl_if ctl_a ();
    cc_coef_scheduler #(.PX_WIDTH(10), .FRACT_WIDTH(10), .DRAIN_CYCLES(4)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
        .commit_i(commit), .vid_tvalid_i(tvalid), .vid_tuser_i(tuser),
        .hold_o(hold_a), .busy_o(busy_a), .done_o(done_a), .cc_ctrl_o(ctl_a));
`ifdef CC_SCHED_SOF_SYNC_EN
    logic hold_b, busy_b, done_b;
    cc_ctrl_if ctl_b ();
    cc_coef_scheduler #(.PX_WIDTH(10), .FRACT_WIDTH(10), .DRAIN_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
        .commit_i(commit), .vid_tvalid_i(tvalid), .vid_tuser_i(tuser),
        .hold_o(hold_b), .busy_o(busy_b), .done_o(done_b), .cc_ctrl_o(ctl_b));
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_idle(input string n, input logic lock, input logic [3:0] sel, input logic [31:0] coef,
                              input logic done, input logic hold, input logic busy);
        check({n, ".lock"}, 32'(lock), 32'd0);
        check({n, ".sel"},  32'(sel),  32'd0);
        check({n, ".coef"}, coef,      32'd0);
        check({n, ".done"}, 32'(done), 32'd0);
        check({n, ".hold"}, 32'(hold), 32'd0);
        check({n, ".busy"}, 32'(busy), 32'd0);
    endtask

    // expected write windows follow the timing rules: SOF at M -> writes M+D+1..M+D+12; no sync -> commit+1..
    task automatic expect_dut(input string n, input int d, input int c, input int c1, input int c2,
                              input int s1, input int s2, input logic lock, input logic [3:0] sel,
                              input logic [31:0] coef, input logic done, input logic hold, input logic busy);
        int st1, st2, k;
        logic in1, in2, exp_hold;
`ifdef CC_SCHED_SOF_SYNC_EN
        st1 = s1 + d + 1;
        st2 = (s2 >= 0) ? s2 + d + 1 : -100;
        exp_hold = (c >= s1 && c <= st1 + 11) || (s2 >= 0 && c >= s2 && c <= st2 + 11);
`else
        st1 = c1 + 1;
        st2 = (c2 >= 0) ? st1 + 12 : -100;
        exp_hold = 1'b0;
`endif
        in1 = c >= st1 && c <= st1 + 11;
        in2 = c >= st2 && c <= st2 + 11;
        check({n, ".lock"}, 32'(lock), 32'(in1 || in2));
        if (in1 || in2) begin
            k = in1 ? c - st1 : c - st2;
            check({n, ".sel"}, 32'(sel), 32'(k));
            check({n, ".coef"}, coef, 32'(in1 ? e1[k] : e2[k]));
        end
        check({n, ".done"}, 32'(done), 32'(c == st1 + 12 || c == st2 + 12));
        check({n, ".hold"}, 32'(hold), 32'(exp_hold));
        check({n, ".busy"}, 32'(busy), 32'(c > c1 && c <= ((st2 >= 0) ? st2 : st1) + 11));
    endtask

    task automatic add_wr(input int c, input logic [3:0] s, input logic [CW-1:0] d);
        wr_t w;
        w.c = c;
        w.s = s;
        w.d = d;
        wq.push_back(w);
    endtask

    task automatic run(input int len, input int c1, input int c2, input int s1, input int s2);
        for (int c = 0; c < len; c++) begin
            cyc    = c;
            commit = (c == c1 || c == c2);
            tvalid = (c == s1 || c == s2);
            tuser  = tvalid;
            wr_en  = 1'b0;
            foreach (wq[i]) if (wq[i].c == c) begin
                wr_en   = 1'b1;
                wr_sel  = wq[i].s;
                wr_data = wq[i].d;
            end
            #1;
            expect_dut("a", 4, c, c1, c2, s1, s2, ctl_a.coef_lock, ctl_a.coef_sel, ctl_a.coef, done_a, hold_a, busy_a);
`ifdef CC_SCHED_SOF_SYNC_EN
            expect_dut("b", 0, c, c1, c2, s1, s2, ctl_b.coef_lock, ctl_b.coef_sel, ctl_b.coef, done_b, hold_b, busy_b);
`endif
            @(posedge clk);
            #1;
        end
        commit = 1'b0;
        tvalid = 1'b0;
        tuser  = 1'b0;
        wr_en  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        commit = 1'b0;
        wr_en  = 1'b0;
        tvalid = 1'b0;
        tuser  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        e1 = init_tab;
        e2 = init_tab;
        wq.delete();
    endtask

    initial begin
        tvalid = 1'b1;
        tuser  = 1'b1;
        #12;
        check_idle("rst.a", ctl_a.coef_lock, ctl_a.coef_sel, ctl_a.coef, done_a, hold_a, busy_a);
`ifdef CC_SCHED_SOF_SYNC_EN
        check_idle("rst.b", ctl_b.coef_lock, ctl_b.coef_sel, ctl_b.coef, done_b, hold_b, busy_b);
`endif
        do_reset();
        run(40, 3, -1, 20, -1);

        do_reset();
        add_wr(0, 4'd0, 21'h000400);
        add_wr(1, 4'd5, 21'h000800);
        add_wr(2, 4'd11, 21'h1FFFFF);
        add_wr(3, 4'd12, 21'h00AAAA);
        add_wr(4, 4'd13, 21'h005555);
        add_wr(5, 4'd3, 21'h012345);
        e1[0]  = 21'h000400;
        e1[5]  = 21'h000800;
        e1[11] = 21'h1FFFFF;
        e1[3]  = 21'h012345;
        run(30, 5, -1, 10, -1);

        do_reset();
        add_wr(3, 4'd5, 21'h000800);
`ifdef CC_SCHED_SOF_SYNC_EN
        e1[5] = 21'h000800;
`else
        e2[5] = 21'h000800;
`endif
        run(32, 1, 5, 12, -1);

        do_reset();
        add_wr(11, 4'd11, 21'h00ABCD);
        e2[11] = 21'h00ABCD;
        run(50, 1, 11, 5, 30);

        do_reset();
        run(E_LEN, 1, -1, 3, -1);
        cyc = E_LEN;
        check("mid.lock_pre", 32'(ctl_a.coef_lock), 32'd1);
        check("mid.sel_pre", 32'(ctl_a.coef_sel), 32'd5);
        rst_n = 1'b0;
        #1;
        check_idle("mid_rst.a", ctl_a.coef_lock, ctl_a.coef_sel, ctl_a.coef, done_a, hold_a, busy_a);
`ifdef CC_SCHED_SOF_SYNC_EN
        check_idle("mid_rst.b", ctl_b.coef_lock, ctl_b.coef_sel, ctl_b.coef, done_b, hold_b, busy_b);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        tvalid = 1'b1;
        tuser  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cyc = E_LEN + 2 + i;
            check_idle("post_rst.a", ctl_a.coef_lock, ctl_a.coef_sel, ctl_a.coef, done_a, hold_a, busy_a);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
